gobou_ctrl_layer: RTL and testbench
===================================

// Module: gobou_ctrl_layer
// PURPOSE
//  Layer sequencer for the gobou FC engine. Per req, walks out-neurons in groups of CORE and, for each group,
//  streams total_in input/weight reads. Drives ctrl_bus (start/valid/stop) into the MAC -> bias -> activation
//  pipeline. Presents bias/writeback addresses. Paces groups so downstream drains before the next group starts.
// PARAMETERS
//  CORE     16  out-neurons computed in parallel per group (one weight word = CORE weights)
//  DIM_W    16  width of total_in / total_out
//  IADDR_W  12  image-memory address width (inputs and outputs share it)
//  WADDR_W  12  weight-memory address width
//  BADDR_W   8  bias-memory address width (one word per group)
//  D_GAP     8  idle cycles after each group's stop; must be >= downstream latency incl. D_BIAS
// PORTS
//  clk         in   1        clock
//  xrst        in   1        async active-low reset
//  req         in   1        start-layer pulse; sampled only in S_IDLE
//  ack         out  1        1 = idle/done, 0 = busy
//  total_in    in   DIM_W    input features per neuron; latched at req
//  total_out   in   DIM_W    output neurons; latched at req
//  in_offset   in   IADDR_W  image base of input vector; latched at req
//  out_offset  in   IADDR_W  image base of output vector; latched at req
//  img_addr    out  IADDR_W  input read address
//  net_addr    out  WADDR_W  weight read address
//  bias_addr   out  BADDR_W  bias word = group index; held for whole group incl. gap
//  out_addr    out  IADDR_W  out_offset + group*CORE; valid with group_done
//  group_mask  out  CORE     lanes holding real neurons in current group
//  group_done  out  1        1-cycle pulse: current group results ready for writeback
//  out_ctrl    ctrl_bus.master  start/valid/stop to MAC stage
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset xrst is asynchronous and active-low.
//  - All outputs registered. While xrst=0: ack=1 and every other output 0. State is S_IDLE, counters 0.
//  - States:
//      S_IDLE: ack=1. req=1 latches params and clears counters.
//        -> S_DONE if total_in==0 or total_out==0.
//        -> S_RUN otherwise.
//      S_RUN: one valid per cycle, i = 0..total_in-1.
//        img_addr = in_offset + i. net_addr = running count over whole layer.
//        start with i==0, stop with i==total_in-1 (same cycle when total_in==1). -> S_GAP after stop.
//      S_GAP: D_GAP cycles with valid=0. group_done=1 in last gap cycle.
//        -> S_RUN with group+1 if more groups, else S_DONE.
//      S_DONE: one cycle with ack=0. -> S_IDLE (ack=1 next cycle).
//  - Latency: req at cycle 0 -> ack=0 and first start/valid at cycle 1.
//  - net_addr does not reset between groups. Weights are stored group-major, total_in words per group.
//  - groups = ceil(total_out/CORE).
//      group_mask = all ones except last group = (1<<(total_out mod CORE))-1 when the remainder is nonzero.
//  - Address arithmetic wraps modulo 2^width. No saturation, no error flag.
//  - req while ack=0 is ignored entirely; latched params unchanged.
//  - xrst low mid-layer aborts immediately. No partial group_done; restart requires a new req.
// STRUCTURE
//  - gobou.svh: CORE, D_BIAS, D_GAP defaults, ctrl_reg struct, enum ctrl_layer_state_t {S_IDLE,S_RUN,S_GAP,S_DONE}.
//  - Sub-module gobou_ctrl_count: loadable up-counter with max compare and last flag.
//    Instantiated for i (input), gap and group.
// TESTING  (CORE=16, D_GAP=8)
//  1. total_in=4, total_out=16, in_offset=0x10, out_offset=0x80, req@0:
//     valid cycles 1-4, img_addr 0x10-0x13, net_addr 0-3, start@1, stop@4,
//     group_done@12 with out_addr=0x80 and mask=0xFFFF, ack=0 cycles 1-13, ack=1@14.
//  2. total_in=3, total_out=40: three groups, bias_addr 0,1,2, masks FFFF,FFFF,00FF,
//     net_addr 0..8 contiguous, out_addr out_offset+0/16/32.
//  3. total_in=1, total_out=16: start, valid and stop all in the same single cycle;
//     group_done 8 cycles later.
//  4. total_out=0 (and separately total_in=0): valid never asserted,
//     ack low for exactly one cycle (S_DONE), no group_done.
//  5. req pulsed again at cycle 2 of test 1 with different params:
//     no effect, sequence identical to test 1.
//  6. xrst low during S_RUN of group 1 (test 2 stimulus): outputs 0 and ack=1 asynchronously;
//     after release, a new req (test 1 params) produces exactly the test 1 trace.

Source files
------------

// File: rtl/gobou_pkg.sv
// Shared types and default sizes for the gobou FC engine control path.
package gobou_pkg;

  localparam int CORE_DEF  = 16;
  localparam int D_BIAS    = 4;
  localparam int D_GAP_DEF = 8;

  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_reg_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } ctrl_layer_state_t;

endpackage

// File: rtl/gobou_ctrl_count.sv
// Loadable up-counter with a compare against a runtime maximum.
module gobou_ctrl_count #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign last = (count == max);

endmodule

// File: rtl/gobou_ctrl_layer.sv
// Layer sequencer: walks out-neuron groups of CORE and streams total_in
// input/weight reads per group, pacing groups so the downstream pipe drains.
module gobou_ctrl_layer
  import gobou_pkg::*;
#(
  parameter int CORE    = CORE_DEF,
  parameter int DIM_W   = 16,
  parameter int IADDR_W = 12,
  parameter int WADDR_W = 12,
  parameter int BADDR_W = 8,
  parameter int D_GAP   = D_GAP_DEF
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  output logic               ack,
  input  logic [DIM_W-1:0]   total_in,
  input  logic [DIM_W-1:0]   total_out,
  input  logic [IADDR_W-1:0] in_offset,
  input  logic [IADDR_W-1:0] out_offset,
  output logic [IADDR_W-1:0] img_addr,
  output logic [WADDR_W-1:0] net_addr,
  output logic [BADDR_W-1:0] bias_addr,
  output logic [IADDR_W-1:0] out_addr,
  output logic [CORE-1:0]    group_mask,
  output logic               group_done,
  output ctrl_reg_t          out_ctrl
);

  localparam int GAP_W = $clog2(D_GAP + 1);

  ctrl_layer_state_t  state;
  logic [DIM_W-1:0]   tin_q;
  logic [DIM_W-1:0]   tout_q;
  logic [IADDR_W-1:0] in_off_q;
  logic [DIM_W-1:0]   grp_max;

  logic               i_clr, i_inc, i_last;
  logic               gap_clr, gap_inc, gap_last;
  logic               grp_clr, grp_inc, grp_last;
  logic [DIM_W-1:0]   i_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [DIM_W-1:0]   grp_cnt;

  // Last group carries only the remainder lanes when total_out is not a multiple of CORE.
  function automatic logic [CORE-1:0] lane_mask(input logic last_grp,
                                                 input logic [DIM_W-1:0] tout);
    logic [DIM_W-1:0] rem;
    rem       = tout % DIM_W'(CORE);
    lane_mask = '1;
    if (last_grp && (rem != '0)) begin
      lane_mask = (CORE'(1) << rem) - CORE'(1);
    end
  endfunction

  assign grp_max = (tout_q - DIM_W'(1)) / DIM_W'(CORE);

  gobou_ctrl_count #(.W(DIM_W)) u_cnt_i (
    .clk(clk), .xrst(xrst), .clr(i_clr), .inc(i_inc),
    .max(tin_q - DIM_W'(1)), .count(i_cnt), .last(i_last)
  );

  gobou_ctrl_count #(.W(GAP_W)) u_cnt_gap (
    .clk(clk), .xrst(xrst), .clr(gap_clr), .inc(gap_inc),
    .max(GAP_W'(D_GAP - 1)), .count(gap_cnt), .last(gap_last)
  );

  gobou_ctrl_count #(.W(DIM_W)) u_cnt_grp (
    .clk(clk), .xrst(xrst), .clr(grp_clr), .inc(grp_inc),
    .max(grp_max), .count(grp_cnt), .last(grp_last)
  );

  always_comb begin
    i_clr   = 1'b0;
    i_inc   = 1'b0;
    gap_clr = 1'b0;
    gap_inc = 1'b0;
    grp_clr = 1'b0;
    grp_inc = 1'b0;
    case (state)
      S_IDLE: if (req) begin
        i_clr   = 1'b1;
        gap_clr = 1'b1;
        grp_clr = 1'b1;
      end
      S_RUN: begin
        if (i_last) gap_clr = 1'b1;
        else        i_inc   = 1'b1;
      end
      S_GAP: begin
        if (!gap_last) begin
          gap_inc = 1'b1;
        end else if (!grp_last) begin
          grp_inc = 1'b1;
          i_clr   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Layer parameters are plain data captured on an accepted req.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      tin_q    <= total_in;
      tout_q   <= total_out;
      in_off_q <= in_offset;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state      <= S_IDLE;
      ack        <= 1'b1;
      out_ctrl   <= '0;
      img_addr   <= '0;
      net_addr   <= '0;
      bias_addr  <= '0;
      out_addr   <= '0;
      group_mask <= '0;
      group_done <= 1'b0;
    end else begin
      group_done <= 1'b0;
      case (state)
        S_IDLE: begin
          ack      <= 1'b1;
          out_ctrl <= '0;
          if (req) begin
            ack       <= 1'b0;
            img_addr  <= in_offset;
            net_addr  <= '0;
            bias_addr <= '0;
            out_addr  <= out_offset;
            if (total_in == '0 || total_out == '0) begin
              state      <= S_DONE;
              group_mask <= '0;
            end else begin
              state      <= S_RUN;
              out_ctrl   <= '{start: 1'b1, valid: 1'b1, stop: (total_in == DIM_W'(1))};
              group_mask <= lane_mask(total_out <= DIM_W'(CORE), total_out);
            end
          end
        end
        S_RUN: begin
          if (i_last) begin
            state      <= S_GAP;
            out_ctrl   <= '0;
            group_done <= (D_GAP == 1);
          end else begin
            out_ctrl <= '{start: 1'b0, valid: 1'b1,
                          stop: ((i_cnt + DIM_W'(1)) == (tin_q - DIM_W'(1)))};
            img_addr <= img_addr + IADDR_W'(1);
            net_addr <= net_addr + WADDR_W'(1);
          end
        end
        S_GAP: begin
          if (!gap_last) begin
            group_done <= ((gap_cnt + GAP_W'(1)) == GAP_W'(D_GAP - 1));
          end else if (grp_last) begin
            state <= S_DONE;
          end else begin
            // Next group re-reads the whole input vector; weights continue contiguously.
            state      <= S_RUN;
            out_ctrl   <= '{start: 1'b1, valid: 1'b1, stop: (tin_q == DIM_W'(1))};
            img_addr   <= in_off_q;
            net_addr   <= net_addr + WADDR_W'(1);
            bias_addr  <= bias_addr + BADDR_W'(1);
            out_addr   <= out_addr + IADDR_W'(CORE);
            group_mask <= lane_mask((grp_cnt + DIM_W'(1)) == grp_max, tout_q);
          end
        end
        default: begin
          state      <= S_IDLE;
          ack        <= 1'b1;
          out_ctrl   <= '0;
          img_addr   <= '0;
          net_addr   <= '0;
          bias_addr  <= '0;
          out_addr   <= '0;
          group_mask <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gobou_ctrl_layer.sv
// Directed bench for the gobou layer sequencer (CORE=16, D_GAP=8).
module tb_gobou_ctrl_layer;
  import gobou_pkg::*;

  logic        clk = 1'b0;
  logic        xrst;
  logic        req;
  logic        ack;
  logic [15:0] total_in, total_out;
  logic [11:0] in_offset, out_offset;
  logic [11:0] img_addr, net_addr, out_addr;
  logic [7:0]  bias_addr;
  logic [15:0] group_mask;
  logic        group_done;
  ctrl_reg_t   out_ctrl;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gobou_ctrl_layer #(
    .CORE(16), .DIM_W(16), .IADDR_W(12), .WADDR_W(12), .BADDR_W(8), .D_GAP(8)
  ) dut (
    .clk(clk), .xrst(xrst), .req(req), .ack(ack),
    .total_in(total_in), .total_out(total_out),
    .in_offset(in_offset), .out_offset(out_offset),
    .img_addr(img_addr), .net_addr(net_addr), .bias_addr(bias_addr),
    .out_addr(out_addr), .group_mask(group_mask), .group_done(group_done),
    .out_ctrl(out_ctrl)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ack"},   int'(ack), 1);
    chk({tag, " ctrl"},  int'(out_ctrl), 0);
    chk({tag, " img"},   int'(img_addr), 0);
    chk({tag, " net"},   int'(net_addr), 0);
    chk({tag, " bias"},  int'(bias_addr), 0);
    chk({tag, " out"},   int'(out_addr), 0);
    chk({tag, " mask"},  int'(group_mask), 0);
    chk({tag, " gdone"}, int'(group_done), 0);
  endtask

  // Caller is at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic do_req(input int tin, input int tout, input int io, input int oo);
    total_in   = 16'(tin);
    total_out  = 16'(tout);
    in_offset  = 12'(io);
    out_offset = 12'(oo);
    req        = 1'b1;
    @(negedge clk);
    req        = 1'b0;
  endtask

  // Expected cycle trace: group g runs at cycles 1+g*(tin+8) .. , gap 8 cycles,
  // group_done in the last gap cycle, then one S_DONE cycle, then idle.
  task automatic trace(input int id, input int tin, input int tout, input int io,
                       input int oo, input bit poke);
    int groups, per, last_c, k, g, p, rem, exp_mask;
    bit vld;
    groups = (tout + 15) / 16;
    rem    = tout % 16;
    do_req(tin, tout, io, oo);
    if (tin == 0 || tout == 0) begin
      chk($sformatf("t%0d c1 ack", id), int'(ack), 0);
      chk($sformatf("t%0d c1 valid", id), int'(out_ctrl.valid), 0);
      chk($sformatf("t%0d c1 gdone", id), int'(group_done), 0);
      @(negedge clk);
      chk($sformatf("t%0d c2 ack", id), int'(ack), 1);
      chk($sformatf("t%0d c2 valid", id), int'(out_ctrl.valid), 0);
      chk($sformatf("t%0d c2 gdone", id), int'(group_done), 0);
      return;
    end
    per    = tin + 8;
    last_c = groups * per;
    for (int c = 1; c <= last_c + 2; c++) begin
      if (c > 1) @(negedge clk);
      if (poke && c == 2) begin
        req = 1'b1; total_in = 16'd7; total_out = 16'd5;
        in_offset = 12'h555; out_offset = 12'h333;
      end
      if (poke && c == 3) req = 1'b0;
      if (c <= last_c) begin
        k = c - 1; g = k / per; p = k % per;
        vld = (p < tin);
        exp_mask = (g == groups - 1 && rem != 0) ? ((1 << rem) - 1) : 'hFFFF;
        chk($sformatf("t%0d c%0d ack", id, c), int'(ack), 0);
        chk($sformatf("t%0d c%0d valid", id, c), int'(out_ctrl.valid), int'(vld));
        chk($sformatf("t%0d c%0d start", id, c), int'(out_ctrl.start), int'(p == 0));
        chk($sformatf("t%0d c%0d stop", id, c), int'(out_ctrl.stop), int'(p == tin - 1));
        chk($sformatf("t%0d c%0d gdone", id, c), int'(group_done), int'(p == per - 1));
        chk($sformatf("t%0d c%0d bias", id, c), int'(bias_addr), g & 'hFF);
        chk($sformatf("t%0d c%0d mask", id, c), int'(group_mask), exp_mask);
        chk($sformatf("t%0d c%0d out", id, c), int'(out_addr), (oo + 16 * g) & 'hFFF);
        if (vld) begin
          chk($sformatf("t%0d c%0d img", id, c), int'(img_addr), (io + p) & 'hFFF);
          chk($sformatf("t%0d c%0d net", id, c), int'(net_addr), (g * tin + p) & 'hFFF);
        end
      end else if (c == last_c + 1) begin
        chk($sformatf("t%0d c%0d done ack", id, c), int'(ack), 0);
        chk($sformatf("t%0d c%0d done valid", id, c), int'(out_ctrl.valid), 0);
        chk($sformatf("t%0d c%0d done gdone", id, c), int'(group_done), 0);
      end else begin
        chk($sformatf("t%0d c%0d idle ack", id, c), int'(ack), 1);
        chk($sformatf("t%0d c%0d idle valid", id, c), int'(out_ctrl.valid), 0);
      end
    end
  endtask

  initial begin
    xrst = 1'b0; req = 1'b0;
    total_in = '0; total_out = '0; in_offset = '0; out_offset = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    xrst = 1'b1;
    @(negedge clk);

    // Single group, hand points: group_done at 12 with 0x80/FFFF, ack high at 14.
    trace(1, 4, 16, 'h10, 'h80, 1'b0);
    // Three groups with a partial last group.
    trace(2, 3, 40, 'h20, 'h100, 1'b0);
    // One input per neuron: start/valid/stop coincide.
    trace(3, 1, 16, 'h40, 'h90, 1'b0);
    // Degenerate layers.
    trace(4, 5, 0, 'h10, 'h80, 1'b0);
    trace(5, 0, 16, 'h10, 'h80, 1'b0);
    // Busy req ignored.
    trace(6, 4, 16, 'h10, 'h80, 1'b1);
    // Address wrap at the top of the image space.
    trace(7, 2, 20, 'hFFF, 'hFF8, 1'b0);

    // Abort during group 1 run of the three-group layer.
    do_req(3, 40, 'h20, 'h100);
    repeat (12) @(negedge clk);
    chk("abort pre valid", int'(out_ctrl.valid), 1);
    chk("abort pre bias", int'(bias_addr), 1);
    #2 xrst = 1'b0;
    #1 chk_idle_outputs("abort async");
    @(negedge clk);
    chk_idle_outputs("abort held");
    xrst = 1'b1;
    @(negedge clk);
    trace(8, 4, 16, 'h10, 'h80, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
